// File: rtl/trap_return_unit_if.sv
// ============================================================================
//  Module   : trap_return_unit_if
//  Purpose  : Return-request and fetch-redirect handshakes of the trap return unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_return_unit_if #(
    parameter int XLEN = 32
);
    logic            ret_valid;
    logic            ret_type;
    logic            ret_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            redirect_ready;

    modport master (
        output ret_valid, ret_type, redirect_ready,
        input  ret_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  ret_valid, ret_type, redirect_ready,
        output ret_ready, redirect_valid, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/trap_return_unit.sv
// ============================================================================
//  Module   : trap_return_unit
//  Purpose  : Sequences MRET/SRET (drain, status restore, fetch redirect) and trap entry.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_return_unit #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    trap_return_unit_if.slave    bus,
    input  wire logic            pipe_empty,
    input  wire logic [XLEN-1:0] mepc,
    input  wire logic [XLEN-1:0] sepc,
    input  wire logic            trap_enter,
    input  wire logic [1:0]      trap_priv,
    output logic      [1:0]      priv_mode,
    output logic                 mstatus_mie,
    output logic                 mstatus_sie,
    output logic                 mstatus_mpie,
    output logic                 mstatus_spie,
    output logic                 mstatus_spp,
    output logic      [1:0]      mstatus_mpp,
    output logic                 illegal_ret,
    output logic                 drain_timeout
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DRAIN    = 2'd1;
    localparam logic [1:0] S_RESTORE  = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    localparam logic [1:0] c_PRIV_U   = 2'b00;
    localparam logic [1:0] c_PRIV_S   = 2'b01;
    localparam logic [1:0] c_PRIV_M   = 2'b11;
    localparam logic [7:0] c_DRAIN_LAST = 8'd254;

    logic [1:0]      r_state;
    logic [1:0]      w_next;
    logic [7:0]      r_cnt;
    logic            r_type;
    logic [XLEN-1:0] r_epc;
    logic [1:0]      r_priv;
    logic            r_mie, r_mpie, r_sie, r_spie, r_spp;
    logic [1:0]      r_mpp;
    logic            r_illegal, r_timeout;

    logic w_ret_illegal, w_accept, w_reject, w_cnt_inc, w_timeout, w_restore, w_trap_s;

    // SRET only needs S or above; MRET needs M.
    assign w_ret_illegal = bus.ret_type ? (r_priv == c_PRIV_U) : (r_priv != c_PRIV_M);
    assign w_accept  = (r_state == S_IDLE) && bus.ret_valid && !trap_enter && !w_ret_illegal;
    assign w_reject  = (r_state == S_IDLE) && bus.ret_valid && !trap_enter &&  w_ret_illegal;
    assign w_cnt_inc = (r_state == S_DRAIN) && !pipe_empty && !trap_enter;
    assign w_timeout = w_cnt_inc && (r_cnt == c_DRAIN_LAST);
    assign w_restore = (r_state == S_RESTORE) && !trap_enter;
    assign w_trap_s  = (trap_priv == c_PRIV_S);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (trap_enter) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:     if (w_accept) w_next = S_DRAIN;
                S_DRAIN:    if (pipe_empty) w_next = S_RESTORE;
                            else if (w_timeout) w_next = S_IDLE;
                S_RESTORE:  w_next = S_REDIRECT;
                S_REDIRECT: if (bus.redirect_ready) w_next = S_IDLE;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.ret_ready      = (r_state == S_IDLE);
        bus.redirect_valid = (r_state == S_REDIRECT);
        bus.redirect_pc    = '0;
        if (r_state == S_REDIRECT) bus.redirect_pc = {r_epc[XLEN-1:2], 2'b00};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_type    <= 1'b0;
            r_epc     <= '0;
            r_priv    <= c_PRIV_M;
            r_mie     <= 1'b0;
            r_mpie    <= 1'b0;
            r_sie     <= 1'b0;
            r_spie    <= 1'b0;
            r_spp     <= 1'b0;
            r_mpp     <= c_PRIV_U;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_illegal <= w_reject;
            r_timeout <= w_timeout;
            r_cnt     <= (w_cnt_inc && !w_timeout) ? r_cnt + 8'd1 : 8'd0;
            if (w_accept) begin
                r_type <= bus.ret_type;
                r_epc  <= bus.ret_type ? sepc : mepc;
            end
            // Trap entry outranks a restore landing on the same edge.
            if (trap_enter) begin
                if (w_trap_s) begin
                    r_spp  <= r_priv[0];
                    r_spie <= r_sie;
                    r_sie  <= 1'b0;
                    r_priv <= c_PRIV_S;
                end else begin
                    r_mpp  <= r_priv;
                    r_mpie <= r_mie;
                    r_mie  <= 1'b0;
                    r_priv <= c_PRIV_M;
                end
            end else if (w_restore) begin
                if (r_type) begin
                    r_priv <= {1'b0, r_spp};
                    r_sie  <= r_spie;
                    r_spie <= 1'b1;
                    r_spp  <= 1'b0;
                end else begin
                    r_priv <= r_mpp;
                    r_mie  <= r_mpie;
                    r_mpie <= 1'b1;
                    r_mpp  <= c_PRIV_U;
                end
            end
        end
    end

    assign priv_mode     = r_priv;
    assign mstatus_mie   = r_mie;
    assign mstatus_sie   = r_sie;
    assign mstatus_mpie  = r_mpie;
    assign mstatus_spie  = r_spie;
    assign mstatus_spp   = r_spp;
    assign mstatus_mpp   = r_mpp;
    assign illegal_ret   = r_illegal;
    assign drain_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_trap_return_unit.sv
// ============================================================================
//  Module   : tb_trap_return_unit
//  Purpose  : Self-checking bench: return vector table, scoreboarded redirects, corner sequences.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_return_unit;

    logic        clk;
    logic        rst_n;
    logic        pipe_empty;
    logic [31:0] mepc, sepc;
    logic        trap_enter;
    logic [1:0]  trap_priv;
    logic [1:0]  priv_mode, mstatus_mpp;
    logic        mstatus_mie, mstatus_sie, mstatus_mpie, mstatus_spie, mstatus_spp;
    logic        illegal_ret, drain_timeout;

    trap_return_unit_if #(.XLEN(32)) bus ();

    trap_return_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .pipe_empty(pipe_empty),
        .mepc(mepc), .sepc(sepc), .trap_enter(trap_enter), .trap_priv(trap_priv),
        .priv_mode(priv_mode), .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie),
        .mstatus_mpie(mstatus_mpie), .mstatus_spie(mstatus_spie), .mstatus_spp(mstatus_spp),
        .mstatus_mpp(mstatus_mpp), .illegal_ret(illegal_ret), .drain_timeout(drain_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_trap;
        logic [1:0]  tp;
        logic        rt;
        logic [31:0] epc;
        int          rdly;
        logic        exp_ill;
        logic [31:0] exp_pc;
        logic [1:0]  exp_priv;
    } vec_t;

    vec_t        tbl [9];
    logic [31:0] sb_q [$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference architectural state
    logic [1:0] m_priv, m_mpp;
    logic       m_mie, m_mpie, m_sie, m_spie, m_spp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] dut_csr();
        return {23'd0, priv_mode, mstatus_mpp, mstatus_mie, mstatus_mpie,
                mstatus_sie, mstatus_spie, mstatus_spp};
    endfunction

    function automatic logic [31:0] model_csr();
        return {23'd0, m_priv, m_mpp, m_mie, m_mpie, m_sie, m_spie, m_spp};
    endfunction

    task automatic model_reset;
        m_priv = 2'b11; m_mpp = 2'b00;
        m_mie = 0; m_mpie = 0; m_sie = 0; m_spie = 0; m_spp = 0;
    endtask

    task automatic model_trap(input logic [1:0] tp);
        if (tp == 2'b01) begin
            m_spp = m_priv[0]; m_spie = m_sie; m_sie = 1'b0; m_priv = 2'b01;
        end else begin
            m_mpp = m_priv; m_mpie = m_mie; m_mie = 1'b0; m_priv = 2'b11;
        end
    endtask

    task automatic model_restore(input logic rt);
        if (rt) begin
            m_priv = {1'b0, m_spp}; m_sie = m_spie; m_spie = 1'b1; m_spp = 1'b0;
        end else begin
            m_priv = m_mpp; m_mie = m_mpie; m_mpie = 1'b1; m_mpp = 2'b00;
        end
    endtask

    task automatic do_trap(input logic [1:0] tp);
        trap_enter = 1'b1; trap_priv = tp;
        tick;
        trap_enter = 1'b0;
        model_trap(tp);
        check("csr_after_trap", dut_csr(), model_csr());
    endtask

    task automatic drive_ret(input logic rt, input logic [31:0] epc);
        bus.ret_valid = 1'b1; bus.ret_type = rt;
        // The unused epc carries a distinct value to catch a wrong select.
        if (rt) begin sepc = epc; mepc = ~epc; end
        else    begin mepc = epc; sepc = ~epc; end
    endtask

    task automatic do_ret(input vec_t v);
        drive_ret(v.rt, v.epc);
        if (!v.exp_ill) sb_q.push_back(v.exp_pc);
        tick;
        bus.ret_valid = 1'b0;
        if (v.exp_ill) begin
            check("illegal_pulse", 32'(illegal_ret), 32'd1);
            check("ready_after_illegal", 32'(bus.ret_ready), 32'd1);
            check("csr_unchanged_illegal", dut_csr(), model_csr());
            check("priv_after_illegal", 32'(priv_mode), 32'(v.exp_priv));
            tick;
            check("illegal_one_cycle", 32'(illegal_ret), 32'd0);
        end else begin
            check("ready_low_busy", 32'(bus.ret_ready), 32'd0);
            check("redirect_low_e0", 32'(bus.redirect_valid), 32'd0);
            tick;
            check("redirect_low_e1", 32'(bus.redirect_valid), 32'd0);
            tick;
            check("redirect_high_e2", 32'(bus.redirect_valid), 32'd1);
            model_restore(v.rt);
            check("csr_after_restore", dut_csr(), model_csr());
            check("priv_after_ret", 32'(priv_mode), 32'(v.exp_priv));
            for (int i = 0; i < v.rdly; i++) begin
                tick;
                check("redirect_hold_valid", 32'(bus.redirect_valid), 32'd1);
                check("redirect_hold_pc", bus.redirect_pc, v.exp_pc);
            end
            bus.redirect_ready = 1'b1;
            tick;
            bus.redirect_ready = 1'b0;
            check("redirect_drop", 32'(bus.redirect_valid), 32'd0);
            check("ready_after_ret", 32'(bus.ret_ready), 32'd1);
        end
    endtask

    task automatic monitor_loop;
        logic        prev;
        logic [31:0] exp;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.redirect_valid && !prev) begin
                if (sb_q.size() == 0) begin
                    check("redirect_unexpected", bus.redirect_pc, 32'hxxxx_xxxx);
                end else begin
                    exp = sb_q.pop_front();
                    check("redirect_pc", bus.redirect_pc, exp);
                end
            end
            prev = rst_n && bus.redirect_valid;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{1'b1, 2'b11, 1'b0, 32'h1000_0004, 0, 1'b0, 32'h1000_0004, 2'b11};
        tbl[1] = '{1'b0, 2'b00, 1'b0, 32'h8000_1003, 2, 1'b0, 32'h8000_1000, 2'b00};
        tbl[2] = '{1'b1, 2'b01, 1'b1, 32'h0000_0400, 0, 1'b0, 32'h0000_0400, 2'b00};
        tbl[3] = '{1'b1, 2'b01, 1'b0, 32'h0000_0ABC, 0, 1'b1, 32'h0000_0000, 2'b01};
        tbl[4] = '{1'b1, 2'b01, 1'b1, 32'h0000_2222, 1, 1'b0, 32'h0000_2220, 2'b01};
        tbl[5] = '{1'b0, 2'b00, 1'b1, 32'h5555_0001, 0, 1'b0, 32'h5555_0000, 2'b00};
        tbl[6] = '{1'b0, 2'b00, 1'b1, 32'h0000_0777, 0, 1'b1, 32'h0000_0000, 2'b00};
        tbl[7] = '{1'b1, 2'b00, 1'b0, 32'hFFFF_FFFE, 3, 1'b0, 32'hFFFF_FFFC, 2'b00};
        tbl[8] = '{1'b1, 2'b10, 1'b1, 32'h0000_0123, 0, 1'b0, 32'h0000_0120, 2'b00};

        rst_n = 1'b0; pipe_empty = 1'b1; mepc = '0; sepc = '0;
        trap_enter = 1'b0; trap_priv = 2'b00;
        bus.ret_valid = 1'b0; bus.ret_type = 1'b0; bus.redirect_ready = 1'b0;
        model_reset;
        fork monitor_loop(); join_none
        tick; tick;
        check("reset_csr", dut_csr(), model_csr());
        check("reset_redirect_pc", bus.redirect_pc, 32'd0);
        rst_n = 1'b1;
        check("ready_first_cycle", 32'(bus.ret_ready), 32'd1);

        for (int k = 0; k < 9; k++) begin
            if (tbl[k].do_trap) do_trap(tbl[k].tp);
            do_ret(tbl[k]);
        end

        // Trap and return request on the same edge: trap wins, return dropped.
        drive_ret(1'b0, 32'h0000_9000);
        trap_enter = 1'b1; trap_priv = 2'b11;
        tick;
        trap_enter = 1'b0; bus.ret_valid = 1'b0;
        model_trap(2'b11);
        check("coincident_ready", 32'(bus.ret_ready), 32'd1);
        check("coincident_no_illegal", 32'(illegal_ret), 32'd0);
        check("coincident_csr", dut_csr(), model_csr());
        repeat (4) tick;
        check("coincident_no_redirect", 32'(bus.redirect_valid), 32'd0);

        // Drain timeout with the pipeline never emptying.
        pipe_empty = 1'b0;
        drive_ret(1'b0, 32'h0000_7000);
        tick;
        bus.ret_valid = 1'b0;
        n = 0;
        while (n < 300 && !drain_timeout) begin
            check("no_illegal_in_drain", 32'(illegal_ret), 32'd0);
            tick;
            n++;
        end
        check("timeout_edges", 32'(n), 32'd255);
        check("timeout_ready", 32'(bus.ret_ready), 32'd1);
        check("timeout_csr", dut_csr(), model_csr());
        tick;
        check("timeout_one_cycle", 32'(drain_timeout), 32'd0);
        pipe_empty = 1'b1;

        // Redirect stalled, then aborted by an M-mode trap.
        drive_ret(1'b0, 32'h0000_5678);
        sb_q.push_back(32'h0000_5678);
        tick;
        bus.ret_valid = 1'b0;
        tick; tick;
        model_restore(1'b0);
        check("abort_redirect_up", 32'(bus.redirect_valid), 32'd1);
        check("abort_csr_restored", dut_csr(), model_csr());
        repeat (5) begin
            tick;
            check("abort_hold_valid", 32'(bus.redirect_valid), 32'd1);
        end
        trap_enter = 1'b1; trap_priv = 2'b11;
        tick;
        trap_enter = 1'b0;
        model_trap(2'b11);
        check("abort_redirect_drop", 32'(bus.redirect_valid), 32'd0);
        check("abort_mpp_priv", dut_csr(), model_csr());
        check("abort_ready", 32'(bus.ret_ready), 32'd1);

        // Asynchronous reset while draining.
        pipe_empty = 1'b0;
        drive_ret(1'b0, 32'h0000_ABCD);
        tick;
        bus.ret_valid = 1'b0;
        tick; tick;
        #2 rst_n = 1'b0;
        #1;
        model_reset;
        check("async_reset_csr", dut_csr(), model_csr());
        check("async_reset_pulses", {30'd0, illegal_ret, drain_timeout}, 32'd0);
        check("async_reset_redirect", {bus.redirect_pc[30:0], bus.redirect_valid}, 32'd0);
        check("async_reset_ready", 32'(bus.ret_ready), 32'd1);
        tick; tick;
        rst_n = 1'b1;
        pipe_empty = 1'b1;
        check("release_ready", 32'(bus.ret_ready), 32'd1);
        repeat (8) tick;
        check("no_redirect_after_reset", 32'(bus.redirect_valid), 32'd0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
